// File: rtl/payload_engine_ctrl.sv
// payload_engine_ctrl
// Per-packet sequencer for a bank of regex payload engines: clears the
// engines, streams payload bytes to the character decoder, waits a fixed
// drain for the engine pipeline, then reports one priority-encoded result.
// Optional feature macro: PAYLOAD_CTRL_MATCH_COUNT_EN adds the m_count port
// (population count of the engine match lines at the sample point).
module payload_engine_ctrl #(
  parameter int NUM_ENGINES  = 32,
  parameter int IDX_W        = 5,
  parameter int MAX_LEN      = 1518,
  parameter int LEN_W        = 11,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [7:0]             byte_out,
  output logic                   eng_sod,
  output logic                   eng_en,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_hit,
  output logic [IDX_W-1:0]       m_rule,
  output logic [LEN_W-1:0]       m_len,
  output logic                   m_trunc
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
  ,
  output logic [IDX_W:0]         m_count
`endif
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_REPORT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_s_ready;
  logic               w_sod;
  logic               w_accept;
  logic               w_drain_done;
  logic [LEN_W-1:0]   r_len;
  logic               r_trunc;
  logic [DRN_W-1:0]   r_drain;
  logic [7:0]         r_byte;
  logic               r_eng_en;
  logic               r_m_valid;
  logic               r_m_hit;
  logic [IDX_W-1:0]   r_m_rule;
  logic [LEN_W-1:0]   r_m_len;
  logic               r_m_trunc;

  // Lowest-index set bit wins; zero when nothing is set.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_ENGINES-1:0] v);
    prio_enc = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = IDX_W'(i);
    end
  endfunction

`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
  logic [IDX_W:0] r_m_count;

  // Number of set bits in the match vector.
  function automatic logic [IDX_W:0] pop_cnt(input logic [NUM_ENGINES-1:0] v);
    pop_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      pop_cnt = pop_cnt + {{IDX_W{1'b0}}, v[i]};
    end
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next       = r_state;
    w_s_ready    = 1'b0;
    w_sod        = 1'b0;
    w_accept     = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE:   if (s_valid) w_next = S_CLEAR;
      S_CLEAR: begin
        w_sod  = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        w_s_ready = 1'b1;
        w_accept  = s_valid;
        if (s_valid && s_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == DRN_W'(DRAIN_CYCLES - 1)) begin
          w_drain_done = 1'b1;
          w_next       = S_REPORT;
        end
      end
      S_REPORT: if (m_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Byte forwarding: the strobe is suppressed once MAX_LEN bytes were scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte   <= '0;
      r_eng_en <= 1'b0;
    end else begin
      r_eng_en <= w_accept && (r_len < LEN_W'(MAX_LEN));
      if (w_accept) r_byte <= s_data;
    end
  end

  // Per-packet length, truncation and drain counters, cleared in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_trunc <= 1'b0;
      r_drain <= '0;
    end else if (r_state == S_CLEAR) begin
      r_len   <= '0;
      r_trunc <= 1'b0;
      r_drain <= '0;
    end else begin
      if (w_accept) begin
        if (r_len < LEN_W'(MAX_LEN)) r_len <= r_len + 1'b1;
        else                         r_trunc <= 1'b1;
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
    end
  end

  // Result capture at the end of the drain; held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_hit   <= 1'b0;
      r_m_rule  <= '0;
      r_m_len   <= '0;
      r_m_trunc <= 1'b0;
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
      r_m_count <= '0;
`endif
    end else if (w_drain_done) begin
      r_m_valid <= 1'b1;
      r_m_hit   <= |eng_match;
      r_m_rule  <= prio_enc(eng_match);
      r_m_len   <= r_len;
      r_m_trunc <= r_trunc;
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
      r_m_count <= pop_cnt(eng_match);
`endif
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready  = w_s_ready;
  assign eng_sod  = w_sod;
  assign eng_en   = r_eng_en;
  assign byte_out = r_byte;
  assign m_valid  = r_m_valid;
  assign m_hit    = r_m_hit;
  assign m_rule   = r_m_rule;
  assign m_len    = r_m_len;
  assign m_trunc  = r_m_trunc;
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
  assign m_count  = r_m_count;
`endif

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Randomized bench for payload_engine_ctrl with a packet-level reference model.
module tb_payload_engine_ctrl;
  localparam int NE   = 32;
  localparam int IW   = 5;
  localparam int MAXL = 1518;
  localparam int LW   = 11;
  localparam int DR   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [7:0]    byte_out;
  logic          eng_sod;
  logic          eng_en;
  logic [NE-1:0] eng_match;
  logic          m_valid;
  logic          m_ready;
  logic          m_hit;
  logic [IW-1:0] m_rule;
  logic [LW-1:0] m_len;
  logic          m_trunc;
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
  logic [IW:0]   m_count;
`endif

  payload_engine_ctrl #(
    .NUM_ENGINES(NE), .IDX_W(IW), .MAX_LEN(MAXL), .LEN_W(LW), .DRAIN_CYCLES(DR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .byte_out(byte_out), .eng_sod(eng_sod), .eng_en(eng_en),
    .eng_match(eng_match),
    .m_valid(m_valid), .m_ready(m_ready), .m_hit(m_hit), .m_rule(m_rule),
    .m_len(m_len), .m_trunc(m_trunc)
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
    , .m_count(m_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state: bytes expected on the decoder side, strobe counters.
  logic [7:0] exp_q[$];
  int en_cnt  = 0;
  int sod_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_sod) begin
        sod_cnt++;
        check_eq("sod_excl_en", {31'd0, eng_en}, 32'd0);
      end
      if (eng_en) begin
        en_cnt++;
        if (exp_q.size() == 0) check_eq("en_without_byte", {31'd0, eng_en}, 32'd0);
        else                   check_eq("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic int ref_rule(input logic [NE-1:0] v);
    int r = 0;
    while (r < NE && !v[r]) r++;
    return (r == NE) ? 0 : r;
  endfunction

  // Streams one packet of len bytes with random bubbles; returns early after
  // abort_at accepted bytes when abort_at > 0. Otherwise waits for the report,
  // checks it against the model, holds m_ready low for hold cycles (with a
  // possibly pending next packet) and completes the handshake.
  task automatic send_pkt(input int len, input logic [NE-1:0] mvec, input int hold, input int abort_at);
    int idx = 0;
    int guard = 0;
    bit have = 0;
    bit pend;
    logic [7:0] d;
    int exp_len;
    logic exp_trunc, exp_hit;
    int exp_rl;
    while (idx < len) begin
      @(negedge clk);
      eng_match = $urandom();
      if (!have) begin d = 8'($urandom()); have = 1; end
      s_valid = s_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = d;
      s_last  = (idx == len - 1);
      if (s_valid && s_ready) begin
        if (idx < MAXL) exp_q.push_back(d);
        idx++;
        have = 0;
        if (abort_at > 0 && idx == abort_at) return;
      end
      guard++;
      if (guard > 4 * len + 50) begin
        check_eq("stream_timeout", idx, len);
        return;
      end
    end
    exp_len   = (len < MAXL) ? len : MAXL;
    exp_trunc = (len > MAXL);
    exp_hit   = |mvec;
    exp_rl    = ref_rule(mvec);
    pend      = $urandom_range(0, 1);
    // t+1: drain, engine outputs still settling
    @(negedge clk);
    s_valid = pend; s_last = 1'b0; s_data = 8'($urandom());
    eng_match = $urandom();
    check_eq("drain_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("mvalid_t1", {31'd0, m_valid}, 32'd0);
    // t+2: final match vector presented
    @(negedge clk);
    eng_match = mvec;
    check_eq("mvalid_t2", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check_eq("mvalid_t3", {31'd0, m_valid}, 32'd0);
    // t+4: result must be visible
    @(negedge clk);
    check_eq("mvalid_t4", {31'd0, m_valid}, 32'd1);
    check_eq("m_hit", {31'd0, m_hit}, {31'd0, exp_hit});
    check_eq("m_rule", {27'd0, m_rule}, exp_rl);
    check_eq("m_len", {21'd0, m_len}, exp_len);
    check_eq("m_trunc", {31'd0, m_trunc}, {31'd0, exp_trunc});
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
    check_eq("m_count", {26'd0, m_count}, $countones(mvec));
`endif
    check_eq("sod_pulses", sod_cnt, 1);
    check_eq("en_pulses", en_cnt, exp_len);
    check_eq("bytes_left", exp_q.size(), 0);
    sod_cnt = 0;
    en_cnt  = 0;
    for (int k = 0; k < hold; k++) begin
      m_ready = 1'b0;
      eng_match = $urandom();
      @(negedge clk);
      check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
      check_eq("hold_s_ready", {31'd0, s_ready}, 32'd0);
      check_eq("hold_sod", {31'd0, eng_sod}, 32'd0);
      check_eq("hold_rule", {27'd0, m_rule}, exp_rl);
      check_eq("hold_len", {21'd0, m_len}, exp_len);
      check_eq("hold_hit", {31'd0, m_hit}, {31'd0, exp_hit});
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_eq("mvalid_after_hs", {31'd0, m_valid}, 32'd0);
    check_eq("sod_before_hs", sod_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    eng_match = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_sod", {31'd0, eng_sod}, 32'd0);
    check_eq("rst_en", {31'd0, eng_en}, 32'd0);
    check_eq("rst_byte", {24'd0, byte_out}, 32'd0);
    check_eq("rst_mvalid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_mhit", {31'd0, m_hit}, 32'd0);
    check_eq("rst_mrule", {27'd0, m_rule}, 32'd0);
    check_eq("rst_mlen", {21'd0, m_len}, 32'd0);
    check_eq("rst_mtrunc", {31'd0, m_trunc}, 32'd0);
`ifdef PAYLOAD_CTRL_MATCH_COUNT_EN
    check_eq("rst_mcount", {26'd0, m_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // No match, 10 bytes
    send_pkt(10, '0, 0, 0);
    // Priority between engines 7 and 3
    send_pkt(6, (NE'(1) << 7) | (NE'(1) << 3), 3, 0);
    // Single-byte packet, immediate consume
    send_pkt(1, NE'(1) << 12, 0, 0);
    // Oversized packet
    send_pkt(1520, NE'($urandom()), 2, 0);
    // Long backpressure
    send_pkt(5, NE'(1) << 31, 20, 0);
    // Random packets
    for (int p = 0; p < 15; p++) begin
      logic [NE-1:0] mv;
      mv = ($urandom_range(0, 3) == 0) ? '0 : NE'($urandom() & $urandom());
      send_pkt($urandom_range(1, 40), mv, $urandom_range(0, 5), 0);
    end

    // Reset during stream after 5 accepted bytes
    send_pkt(30, '0, 0, 5);
    @(negedge clk);
    check_eq("en_before_rst", {31'd0, eng_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_mid_en", {31'd0, eng_en}, 32'd0);
    check_eq("rst_mid_mvalid", {31'd0, m_valid}, 32'd0);
    exp_q.delete();
    en_cnt = 0;
    sod_cnt = 0;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(7, NE'(1) << 20, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/payload_engine_ctrl.md
# payload_engine_ctrl

Per-packet sequencer for a bank of regex payload engines. It accepts a payload byte stream over a valid/ready handshake and clears the engine bank with a one-cycle `eng_sod` pulse before each packet. It forwards each byte to the shared character decoder with an aligned `eng_en` strobe. After the last byte and a fixed drain, it samples the sticky per-engine match lines and emits one priority-encoded result per packet. It sits between the packet parser and the alert/classification logic.

## Interface
Parameters:
- `NUM_ENGINES`, 32: number of engine `out` lines.
- `IDX_W`, 5: rule index width; must satisfy 2^IDX_W ≥ NUM_ENGINES.
- `MAX_LEN`, 1518: bytes scanned per packet; later bytes are consumed but not scanned.
- `LEN_W`, 11: byte-count width; must hold MAX_LEN.
- `DRAIN_CYCLES`, 3: cycles from last-byte acceptance to match sampling; must be ≥ 3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_data` in 8: payload byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: final byte of packet.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `byte_out` out 8: registered byte, to the character decoder.
- `eng_sod` out 1: engine clear; drives every engine's `sod`.
- `eng_en` out 1: engine clock enable, aligned with `byte_out`.
- `eng_match` in NUM_ENGINES: engine `out` lines (sticky until `eng_sod`).
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumed.
- `m_hit` out 1: at least one engine matched.
- `m_rule` out IDX_W: lowest-index matching engine; 0 when `m_hit`=0.
- `m_len` out LEN_W: bytes scanned (saturates at MAX_LEN).
- `m_trunc` out 1: packet longer than MAX_LEN.
- `m_count` out IDX_W+1: number of matching engines; present only when PAYLOAD_CTRL_MATCH_COUNT_EN is defined.

## Operation
The controller is a five-state FSM: IDLE, CLEAR, STREAM, DRAIN, REPORT.

- **IDLE:** `s_ready`=0. Go to CLEAR when `s_valid`=1.
- **CLEAR:** one cycle. `eng_sod`=1, `s_ready`=0. Clear the length counter, the trunc flag and the drain counter. Go to STREAM.
- **STREAM:** `s_ready`=1.
  - On each accepted byte: register `byte_out` ← `s_data`, and register `eng_en` ← 1 if the length counter < MAX_LEN, else 0.
  - Increment the length counter, saturating at MAX_LEN.
  - An accepted byte while the counter = MAX_LEN sets trunc.
  - With no accept, `eng_en` registers 0.
  - An accept with `s_last`=1 goes to DRAIN.
- **DRAIN:** `s_ready`=0, `eng_en`=0. Count DRAIN_CYCLES cycles, then go to REPORT.
- **REPORT:** on entry, capture:
  - `m_hit` = OR of `eng_match`.
  - `m_rule` = priority encode, lowest index first.
  - `m_len` and `m_trunc`.
  - `m_valid`=1. Hold all result outputs stable until `m_valid & m_ready`, then go to IDLE.
- A single-byte packet (`s_last` on the first accept) is legal. It yields `m_len`=1.
- `eng_sod` is never asserted while `eng_en`=1.
- `eng_match` is ignored outside the REPORT capture.

## Timing
- Reset values: state IDLE; `s_ready`=0, `eng_sod`=0, `eng_en`=0, `byte_out`=0, `m_valid`=0, `m_hit`=0, `m_rule`=0, `m_len`=0, `m_trunc`=0, `m_count`=0.
- Byte accepted at cycle t: `byte_out`/`eng_en` valid in t+1, engine state registers at the end of t+1, and the end state registers at the end of t+2.
- The match sample occurs at the end of cycle t+DRAIN_CYCLES. `m_valid` rises in cycle t+DRAIN_CYCLES+1.
- First `s_valid` in IDLE at cycle c: CLEAR in c+1, first possible accept in c+2.
- Minimum per-packet overhead: 1 (IDLE) + 1 (CLEAR) + DRAIN_CYCLES + 1 (REPORT) cycles.
- Backpressure: `s_ready` is 0 from DRAIN through REPORT. The next packet waits until the result is consumed.
- `m_ready` asserted in the first REPORT cycle: the result is consumed that cycle and the FSM is in IDLE the next cycle.
- `rst_n` asserted mid-packet: all outputs return to reset values immediately and the partial packet is dropped. The upstream must restart the packet.

## Configuration
- `PAYLOAD_CTRL_MATCH_COUNT_EN` defined: adds the `m_count` port, a population count of `eng_match` captured alongside `m_hit` and held until the handshake.
- Undefined: the port and popcount logic are absent; all other behaviour is identical.

## Test plan
- **No match:** reset, one 10-byte packet, all `eng_match`=0 → exactly one `eng_sod` pulse before the first `eng_en`; ten `eng_en` pulses; `m_valid` with `m_hit`=0, `m_rule`=0, `m_len`=10, `m_trunc`=0.
- **Priority:** `eng_match` bits 7 and 3 set by the sample point → `m_hit`=1, `m_rule`=3; with the macro defined, `m_count`=2.
- **Truncation:** 1520-byte packet → exactly 1518 `eng_en` pulses, `m_len`=1518, `m_trunc`=1.
- **Backpressure:** `m_ready`=0 for 20 cycles with the next packet pending → `s_ready`=0 and outputs stable throughout; the next CLEAR occurs only after the handshake.
- **Drain timing:** single-byte packet accepted at cycle t → `m_valid` first high at t+4 (DRAIN_CYCLES=3); a match asserted at t+2 is reported.
- **Reset:** `rst_n` low during STREAM at byte 5 → `s_ready`, `eng_en`, `m_valid` = 0 the same cycle; after release, a fresh packet reports `m_len` counted from 0.
